// File: rtl/mem_access_seq_pkg.sv
// rtl/mem_access_seq_pkg.sv - shared constants, edit selectors and FSM states for mem_access_seq
package mem_access_seq_pkg;

  localparam int          ADDR_W_DEF  = 12;
  localparam int          DATA_W_DEF  = 16;
  localparam int          REG_TOP_DEF = 8;
  localparam logic [11:0] ADDR_CYR    = 12'o020;

  // Selector order matches the address order of the editing window (CYR, SR, CYL, EDOP).
  typedef enum logic [1:0] {
    SEL_CYR  = 2'd0,
    SEL_SR   = 2'd1,
    SEL_CYL  = 2'd2,
    SEL_EDOP = 2'd3
  } edit_sel_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_READ  = 3'd2,
    S_EDIT  = 3'd3,
    S_WRITE = 3'd4,
    S_RESP  = 3'd5
  } state_e;

endpackage

// File: rtl/mem_access_seq_edit_unit.sv
// rtl/mem_access_seq_edit_unit.sv - combinational CYR/SR/CYL/EDOP word editor
module edit_unit
  import mem_access_seq_pkg::*;
(
  input  logic [15:0] data,
  input  edit_sel_e   sel,
  output logic [15:0] result
);

  logic [14:0] r;
  logic        unused_b15;

  // Editing ignores the incoming bit 15; the result's bit 15 is a sign copy of its bit 14.
  assign unused_b15 = data[15];

  always_comb begin
    r = data[14:0];
    unique case (sel)
      SEL_CYR:  r = {data[0], data[14:1]};
      SEL_SR:   r = {data[14], data[14:1]};
      SEL_CYL:  r = {data[13:0], data[14]};
      SEL_EDOP: r = {8'b0, data[13:7]};
      default:  r = data[14:0];
    endcase
  end

  assign result = {r[14], r};

endmodule

// File: rtl/mem_access_seq.sv
// rtl/mem_access_seq.sv - single-request memory sequencer with AGC editing and register-window write refusal
module mem_access_seq
  import mem_access_seq_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int EDIT_BASE = int'(ADDR_CYR),
  parameter int REG_TOP   = REG_TOP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_reg_hit,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_en,
  input  logic [DATA_W-1:0] mem_result
);

  state_e            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic [ADDR_W-1:0] edit_off;
  logic              in_edit;
  logic              in_reg;
  logic [DATA_W-1:0] edit_src;
  logic [DATA_W-1:0] edited;
  logic              accept;

  // Unsigned offset makes addresses below the window wrap high, so one compare covers both ends.
  assign edit_off = addr_q - ADDR_W'(EDIT_BASE);
  assign in_edit  = edit_off < ADDR_W'(4);
  assign in_reg   = addr_q <= ADDR_W'(REG_TOP);
  assign edit_src = (state == S_EDIT) ? rsp_data : wdata_q;
  assign accept   = (state == S_IDLE) && req_valid;

  edit_unit u_edit (
    .data   (edit_src),
    .sel    (edit_sel_e'(edit_off[1:0])),
    .result (edited)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      rsp_data    <= '0;
      rsp_reg_hit <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_q      <= req_addr;
        wdata_q     <= req_wdata;
        write_q     <= req_write;
        rsp_reg_hit <= 1'b0;
      end
      if (state == S_ADDR && write_q && in_reg) rsp_reg_hit <= 1'b1;
      if (state == S_READ)  rsp_data <= mem_result;
      if (state == S_WRITE) rsp_data <= mem_data_in;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (req_valid) state_nx = S_ADDR;
      S_ADDR:  state_nx = write_q ? (in_reg ? S_RESP : S_WRITE) : S_READ;
      S_READ:  state_nx = in_edit ? S_EDIT : S_RESP;
      S_EDIT:  state_nx = S_RESP;
      S_WRITE: state_nx = S_RESP;
      S_RESP:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Write strobe and data are decoded from the state register so reset kills them at once.
  always_comb begin
    mem_data_in = '0;
    if (state == S_EDIT)  mem_data_in = edited;
    if (state == S_WRITE) mem_data_in = in_edit ? edited : wdata_q;
  end

  assign mem_write_en = (state == S_EDIT) || (state == S_WRITE);
  assign mem_address  = addr_q;
  assign req_ready    = (state == S_IDLE);
  assign rsp_valid    = (state == S_RESP);

endmodule

// File: tb/tb_mem_access_seq.sv
// tb/tb_mem_access_seq.sv - directed self-checking bench for mem_access_seq
module tb_mem_access_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [11:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_reg_hit;
  logic [11:0] mem_address;
  logic [15:0] mem_data_in;
  logic        mem_write_en;
  logic [15:0] mem_result;

  logic [15:0] mem [0:4095];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [15:0] pl_data = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign mem_result = mem[mem_address];

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_address] <= mem_data_in;
    else if (pl_en)   mem[pl_addr] <= pl_data;
  end

  mem_access_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_reg_hit  (rsp_reg_hit),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_write_en (mem_write_en),
    .mem_result   (mem_result)
  );

  task automatic preload(input logic [11:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic start_req(input logic w, input logic [11:0] a, input logic [15:0] d);
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output int np, output int plat, output logic [15:0] pval);
    lat = 1; np = 0; plat = 0; pval = '0;
    while (!rsp_valid && lat < 20) begin
      if (mem_write_en) begin np++; plat = lat; pval = mem_data_in; end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 16'h0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0000", rsp_data); end
    checks++; if (rsp_reg_hit !== 1'b0) begin failures++; $display("FAIL reset_reg_hit got=%b exp=0", rsp_reg_hit); end
    checks++; if (mem_write_en !== 1'b0) begin failures++; $display("FAIL reset_write_en got=%b exp=0", mem_write_en); end
    checks++; if (mem_address !== 12'h0) begin failures++; $display("FAIL reset_mem_address got=%h exp=000", mem_address); end
    checks++; if (mem_data_in !== 16'h0) begin failures++; $display("FAIL reset_mem_data_in got=%h exp=0000", mem_data_in); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_plain_read();
    int lat, np, plat;
    logic [15:0] pval;
    preload(12'o100, 16'h1234);
    start_req(1'b0, 12'o100, 16'h0);
    wait_rsp(lat, np, plat, pval);
    checks++; if (lat !== 3) begin failures++; $display("FAIL plain_read_latency got=%0d exp=3", lat); end
    checks++; if (rsp_data !== 16'h1234) begin failures++; $display("FAIL plain_read_data got=%h exp=1234", rsp_data); end
    checks++; if (np !== 0) begin failures++; $display("FAIL plain_read_pulses got=%0d exp=0", np); end
    checks++; if (mem_address !== 12'o100) begin failures++; $display("FAIL plain_read_addr_hold got=%o exp=100", mem_address); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h1234) begin failures++; $display("FAIL plain_read_rsp_hold valid=%b data=%h exp=1/1234", rsp_valid, rsp_data); end
    finish_rsp();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL plain_read_release valid=%b ready=%b exp=0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_edit_read(input logic [11:0] a, input logic [15:0] raw, input logic [15:0] exp_edit, input string nm);
    int lat, np, plat;
    logic [15:0] pval;
    preload(a, raw);
    start_req(1'b0, a, 16'h0);
    wait_rsp(lat, np, plat, pval);
    checks++; if (lat !== 4) begin failures++; $display("FAIL %s_latency got=%0d exp=4", nm, lat); end
    checks++; if (rsp_data !== raw) begin failures++; $display("FAIL %s_rsp_data got=%h exp=%h", nm, rsp_data, raw); end
    checks++; if (np !== 1 || plat !== 3) begin failures++; $display("FAIL %s_pulse count=%0d cycle=%0d exp=1/3", nm, np, plat); end
    checks++; if (pval !== exp_edit) begin failures++; $display("FAIL %s_pulse_data got=%h exp=%h", nm, pval, exp_edit); end
    checks++; if (mem[a] !== exp_edit) begin failures++; $display("FAIL %s_mem got=%h exp=%h", nm, mem[a], exp_edit); end
    finish_rsp();
  endtask

  task automatic test_write(input logic [11:0] a, input logic [15:0] d, input logic [15:0] exp_st, input string nm);
    int lat, np, plat;
    logic [15:0] pval;
    start_req(1'b1, a, d);
    checks++; if (rsp_reg_hit !== 1'b0) begin failures++; $display("FAIL %s_reg_hit_clear got=%b exp=0", nm, rsp_reg_hit); end
    wait_rsp(lat, np, plat, pval);
    checks++; if (lat !== 3) begin failures++; $display("FAIL %s_latency got=%0d exp=3", nm, lat); end
    checks++; if (np !== 1 || plat !== 2) begin failures++; $display("FAIL %s_pulse count=%0d cycle=%0d exp=1/2", nm, np, plat); end
    checks++; if (rsp_data !== exp_st || rsp_reg_hit !== 1'b0) begin failures++; $display("FAIL %s_rsp data=%h hit=%b exp=%h/0", nm, rsp_data, rsp_reg_hit, exp_st); end
    checks++; if (mem[a] !== exp_st) begin failures++; $display("FAIL %s_mem got=%h exp=%h", nm, mem[a], exp_st); end
    finish_rsp();
  endtask

  task automatic test_plain_edges(input logic [11:0] a, input logic [15:0] raw, input string nm);
    int lat, np, plat;
    logic [15:0] pval;
    preload(a, raw);
    start_req(1'b0, a, 16'h0);
    wait_rsp(lat, np, plat, pval);
    checks++; if (lat !== 3 || np !== 0) begin failures++; $display("FAIL %s lat=%0d pulses=%0d exp=3/0", nm, lat, np); end
    checks++; if (rsp_data !== raw || mem[a] !== raw) begin failures++; $display("FAIL %s_data rsp=%h mem=%h exp=%h", nm, rsp_data, mem[a], raw); end
    finish_rsp();
  endtask

  task automatic test_reg_refuse();
    int lat, np, plat;
    logic [15:0] pval;
    preload(12'd3, 16'h5555);
    start_req(1'b1, 12'd3, 16'hBEEF);
    wait_rsp(lat, np, plat, pval);
    checks++; if (lat !== 2) begin failures++; $display("FAIL refuse_latency got=%0d exp=2", lat); end
    checks++; if (rsp_reg_hit !== 1'b1) begin failures++; $display("FAIL refuse_reg_hit got=%b exp=1", rsp_reg_hit); end
    checks++; if (np !== 0 || mem_write_en !== 1'b0) begin failures++; $display("FAIL refuse_pulses got=%0d en=%b exp=0/0", np, mem_write_en); end
    checks++; if (mem[3] !== 16'h5555) begin failures++; $display("FAIL refuse_mem got=%h exp=5555", mem[3]); end
    finish_rsp();
    checks++; if (rsp_reg_hit !== 1'b1) begin failures++; $display("FAIL refuse_hit_sticky got=%b exp=1", rsp_reg_hit); end
  endtask

  task automatic test_back_to_back();
    int lat, np, plat;
    logic [15:0] pval;
    preload(12'o300, 16'h0A0A);
    preload(12'o301, 16'h0B0B);
    start_req(1'b0, 12'o300, 16'h0);
    wait_rsp(lat, np, plat, pval);
    req_write = 1'b0; req_addr = 12'o301; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin failures++; $display("FAIL stall_cycle%0d ready=%b valid=%b exp=0/1", i, req_ready, rsp_valid); end
      @(posedge clk); #1;
    end
    checks++; if (rsp_data !== 16'h0A0A || mem_address !== 12'o300) begin failures++; $display("FAIL stall_hold data=%h addr=%o exp=0a0a/300", rsp_data, mem_address); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_after_rsp got=%b exp=1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0 || mem_address !== 12'o301) begin failures++; $display("FAIL b2b_accept ready=%b addr=%o exp=0/301", req_ready, mem_address); end
    wait_rsp(lat, np, plat, pval);
    checks++; if (lat !== 3 || rsp_data !== 16'h0B0B) begin failures++; $display("FAIL b2b_second lat=%0d data=%h exp=3/0b0b", lat, rsp_data); end
    finish_rsp();
  endtask

  task automatic test_async_reset();
    preload(12'o200, 16'h0000);
    start_req(1'b1, 12'o200, 16'hABCD);
    @(posedge clk); #1;
    checks++; if (mem_write_en !== 1'b1 || mem_data_in !== 16'hABCD) begin failures++; $display("FAIL arst_in_write en=%b data=%h exp=1/abcd", mem_write_en, mem_data_in); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_write_en !== 1'b0) begin failures++; $display("FAIL arst_write_en got=%b exp=0", mem_write_en); end
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_reg_hit !== 1'b0) begin failures++; $display("FAIL arst_handshake ready=%b valid=%b hit=%b exp=1/0/0", req_ready, rsp_valid, rsp_reg_hit); end
    checks++; if (mem_address !== 12'h0 || mem_data_in !== 16'h0 || rsp_data !== 16'h0) begin failures++; $display("FAIL arst_outputs addr=%h din=%h rsp=%h exp=0", mem_address, mem_data_in, rsp_data); end
    @(posedge clk); #1;
    checks++; if (mem[12'o200] !== 16'h0000) begin failures++; $display("FAIL arst_no_store got=%h exp=0000", mem[12'o200]); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_plain_read();
    test_edit_read(12'o020, 16'h0003, 16'hC001, "cyr_read");
    test_edit_read(12'o021, 16'h4002, 16'hE001, "sr_read");
    test_edit_read(12'o022, 16'h4001, 16'h0003, "cyl_read");
    test_write(12'o023, 16'h0F00, 16'h001E, "edop_write");
    test_write(12'd9, 16'h1357, 16'h1357, "reg_top_plus1_write");
    test_reg_refuse();
    test_write(12'o017, 16'h7FFF, 16'h7FFF, "below_window_write");
    test_plain_edges(12'o024, 16'h8000, "above_window_read");
    test_plain_edges(12'hFFF, 16'h1111, "wrap_read");
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
